// File: rtl/sar_adc_controller_if.sv
// Start/busy/done handshake and result bus between the SAR controller and its consumer.
interface sar_adc_controller_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             continuous;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  modport master (
    output start, continuous, abort,
    input  busy, done, result, result_valid
  );

  modport slave (
    input  start, continuous, abort,
    output busy, done, result, result_valid
  );
endinterface

// File: rtl/sar_adc_controller.sv
// Successive-approximation controller: binary search over the R2R ladder code using a
// synchronized comparator, one fixed settle window per bit.
module sar_adc_controller #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               comparator_state_i,
  output logic [WIDTH-1:0]   r2r_output_o,
  sar_adc_controller_if.slave ctrl
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [WIDTH-1:0] TRIAL_INIT = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_INIT   = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]       trial_q, trial_d;
  logic [WIDTH-1:0]       r2r_q, r2r_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   comp_sync;

  assign comp_sync = sync_q[SYNC_STAGES-1];

  // Comparator synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= comparator_state_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      trial_q   <= '0;
      r2r_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      trial_q   <= trial_d;
      r2r_q     <= r2r_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state; abort beats both the bit decision and the continuous restart
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    trial_d   = trial_q;
    result_d  = result_q;
    valid_d   = valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (!ctrl.abort && ctrl.start) begin
          trial_d   = TRIAL_INIT;
          bit_idx_d = IDX_INIT;
          cnt_d     = CNT_LOAD;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (ctrl.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DECIDE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DECIDE: begin
        if (ctrl.abort) begin
          state_d = S_IDLE;
        end else begin
          trial_d[bit_idx_q] = comp_sync;
          if (bit_idx_q != '0) begin
            bit_idx_d          = bit_idx_q - IDX_W'(1);
            trial_d[bit_idx_d] = 1'b1;
            cnt_d              = CNT_LOAD;
            state_d            = S_SETTLE;
          end else begin
            result_d = trial_d;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (ctrl.abort || !ctrl.continuous) begin
          state_d = S_IDLE;
        end else begin
          trial_d   = TRIAL_INIT;
          bit_idx_d = IDX_INIT;
          cnt_d     = CNT_LOAD;
          state_d   = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_DECIDE);
    done_d = (state_d == S_DONE);
    r2r_d  = (state_d == S_IDLE) ? '0 : trial_d;
  end

  assign r2r_output_o      = r2r_q;
  assign ctrl.busy         = busy_q;
  assign ctrl.done         = done_q;
  assign ctrl.result       = result_q;
  assign ctrl.result_valid = valid_q;

endmodule

// File: doc/sar_adc_controller.md
# sar_adc_controller

Successive-approximation controller that sequences the R2R ladder DAC and the external analog comparator to convert one analog sample into an 8-bit code. It replaces the free-running ramp sweep with a binary search: each bit costs a fixed settle window instead of a full ramp period. It sits between the comparator input pin and the R2R output pins at the ADC top level, with a start/busy/done handshake toward the display/consumer logic.

## Interface

- WIDTH, 8: result and DAC code width (bits).
- SETTLE_CYCLES, 16: clock cycles the DAC code is held before each bit decision; must be ≥ SYNC_STAGES+1.
- SYNC_STAGES, 2: flip-flop stages in the comparator synchronizer.

- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- comparator_state  in  1  asynchronous comparator output; 1 = analog input ≥ DAC voltage.
- start  in  1  conversion request, sampled only in IDLE.
- continuous  in  1  1 = restart automatically after each conversion.
- abort  in  1  synchronous cancel of the conversion in progress.
- r2r_output  out  WIDTH  trial code driven to the R2R ladder.
- result  out  WIDTH  last completed conversion code.
- result_valid  out  1  sticky; set by the first completed conversion.
- busy  out  1  high in SETTLE and DECIDE.
- done  out  1  one-cycle pulse, high in DONE.

## Operation

- States: IDLE, SETTLE, DECIDE, DONE. All outputs registered or decoded from the state register only.
- comparator_state passes through SYNC_STAGES flops (reset 0); decisions use only the synchronized value.
- IDLE: r2r_output = 0. On start=1: trial = 1<<(WIDTH-1), bit_idx = WIDTH-1, cnt = SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: cnt decrements each cycle; on the cycle cnt = 0 go to DECIDE. r2r_output = trial throughout.
- DECIDE (one cycle): if sync comparator = 0, clear trial[bit_idx]; otherwise keep it.
  - If bit_idx > 0: set trial[bit_idx-1], decrement bit_idx, reload cnt, go to SETTLE.
  - If bit_idx = 0: result ← final trial, result_valid ← 1, go to DONE.
- DONE: done = 1 and r2r_output = final code for one cycle.
  - If continuous = 1: load a new trial as in IDLE start and go to SETTLE.
  - Otherwise go to IDLE.
- start is ignored outside IDLE; there is no queuing.
- Clearing continuous mid-conversion lets the current conversion finish, then the block goes to IDLE.
- abort = 1 in SETTLE, DECIDE or DONE: next state IDLE, r2r_output = 0, no done pulse, result and result_valid unchanged. abort has priority over the bit decision and the continuous restart. abort in IDLE is a no-op, and it has priority over start.
- Reset (rst = 0, asynchronous): state IDLE; r2r_output, result, cnt, trial, sync flops = 0; busy, done, result_valid = 0. Reset mid-conversion discards the conversion.

## Timing

- Per bit: SETTLE_CYCLES + 1 cycles.
- Start latency: start sampled at edge E0; done is high in the cycle after edge E0 + WIDTH·(SETTLE_CYCLES+1). This is edge 136 for the defaults.
- busy rises after E0 and falls in the same cycle done rises.
- Continuous mode: done period = WIDTH·(SETTLE_CYCLES+1) + 1 cycles, 137 for the defaults.
- r2r_output changes only on the edge entering SETTLE or DONE.
- Comparator input change to usable decision: ≤ SYNC_STAGES cycles, covered by the settle window.

## Test plan

- Comparator model comparator_state = (vin ≥ r2r_output), vin = 0xA5, start pulse:
  - r2r_output sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - done one cycle at edge 136; result = 0xA5; result_valid = 1.
- Extremes: vin = 0x00 → result 0x00; vin = 0xFF → result 0xFF; vin = 0x80 → result 0x80.
- continuous = 1, vin stepped 0x3C → 0xC3 between conversions → done pulses 137 cycles apart, results 0x3C then 0xC3. Clearing continuous → exactly one more done, then IDLE with busy = 0.
- start pulsed during busy → no effect on timing or result. abort at cycle 50 → IDLE next cycle, r2r_output = 0, no done, result keeps its previous value.
- rst driven low asynchronously mid-SETTLE (between edges) → all outputs 0 immediately. After release, start → normal conversion.
- SETTLE_CYCLES = 4, vin = 0x5A → done at edge 40, result 0x5A.
